regfile_sb: RTL and testbench

- Parametrised successor to the core's 2-read/1-write integer register file.
- Generalised in data width, register count and number of read ports.
- Adds a sequential clear state machine, so all registers are zeroed after reset.
- Adds a per-register busy scoreboard for pending-write tracking.
- Sits in the decode/writeback stage of the RISC-V datapath; x0 reads as zero and is never written.

---
 rtl/regfile_sb.sv | 163 ++++++++++++++++
 tb/tb_regfile_sb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with multiple combinational
// read ports, one write port, a sequential post-reset clear sequence and a
// per-register busy scoreboard for pending-write tracking.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined     -> write-through bypass on every read port (data and busy)
//   not defined -> reads and busy reflect registered state only
//
// x0 always reads as zero, is never written and is never marked busy.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ready,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      busy,
    input  logic                we3,
    input  logic [AW-1:0]       a3,
    input  logic [XLEN-1:0]     wd3,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_a
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Last entry zeroed by the clear sequence; x0 is skipped (counter starts at 1).
    localparam logic [AW-1:0] CNT_FIRST = AW'(1);
    localparam logic [AW-1:0] CNT_LAST  = AW'(NREG - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic [NREG-1:0]   sb_q, sb_d;

    // Storage array; no reset, it is zeroed by the clear sequence instead.
    logic [XLEN-1:0]   rf_mem [NREG];

    logic              wr_fire;
    logic              iss_fire;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [XLEN-1:0]   mem_wdata;

    // Architectural write / issue only count once the file is ready and the
    // target is not x0.
    assign wr_fire  = (state_q == ST_READY) && we3    && (a3    != '0);
    assign iss_fire = (state_q == ST_READY) && iss_en && (iss_a != '0);

    assign ready = ready_q;

    // Next-state logic for the clear sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_READY;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
                ready_d = 1'b0;
            end
        endcase
    end

    // Scoreboard update: clear on writeback, then set on issue so that a new
    // producer issuing in the same cycle supersedes the completing one.
    always_comb begin
        sb_d = sb_q;
        if (wr_fire) begin
            sb_d[a3] = 1'b0;
        end
        if (iss_fire) begin
            sb_d[iss_a] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    // Clear-sequencer state, ready flag and scoreboard registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= CNT_FIRST;
            ready_q <= 1'b0;
            sb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            sb_q    <= sb_d;
        end
    end

    // Single storage write port shared by the clear sequence and writeback.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = a3;
        mem_wdata = wd3;
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = '0;
            end else if (wr_fire) begin
                mem_we = 1'b1;
            end
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            rf_mem[mem_addr] <= mem_wdata;
        end
    end

    // Independent combinational read ports.
    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0]   ra_i;
            logic [XLEN-1:0] rd_v;
            logic            busy_v;

            assign ra_i = ra[gi*AW +: AW];

            // Read mux: x0 forced to zero; optional write-through bypass.
            always_comb begin
                rd_v   = (ra_i == '0) ? '0 : rf_mem[ra_i];
                busy_v = sb_q[ra_i];
`ifdef REGFILE_BYPASS_EN
                if (wr_fire && (ra_i == a3)) begin
                    rd_v = wd3;
                    if (!(iss_en && (iss_a == a3))) begin
                        busy_v = 1'b0;
                    end
                end
`endif
            end

            assign rd[gi*XLEN +: XLEN] = rd_v;
            assign busy[gi]            = busy_v;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a default-parameter instance driven by
// directed and random stimulus against an array/counter reference model, and
// a 64-bit/16-entry/4-port instance checking packing and clear length.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    localparam int B_XLEN = 64;
    localparam int B_NREG = 16;
    localparam int B_NRD  = 4;
    localparam int B_AW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance signals
    logic                reset;
    logic                ready;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      busy;
    logic                we3;
    logic [AW-1:0]       a3;
    logic [XLEN-1:0]     wd3;
    logic                iss_en;
    logic [AW-1:0]       iss_a;

    // Wide instance signals
    logic                    b_reset;
    logic                    b_ready;
    logic [B_NRD*B_AW-1:0]   b_ra;
    logic [B_NRD*B_XLEN-1:0] b_rd;
    logic [B_NRD-1:0]        b_busy;
    logic                    b_we3;
    logic [B_AW-1:0]         b_a3;
    logic [B_XLEN-1:0]       b_wd3;
    logic                    b_iss_en;
    logic [B_AW-1:0]         b_iss_a;

    regfile_sb u_dut (
        .clk    (clk),
        .reset  (reset),
        .ready  (ready),
        .ra     (ra),
        .rd     (rd),
        .busy   (busy),
        .we3    (we3),
        .a3     (a3),
        .wd3    (wd3),
        .iss_en (iss_en),
        .iss_a  (iss_a)
    );

    regfile_sb #(.XLEN(B_XLEN), .NREG(B_NREG), .NRD(B_NRD)) u_dut_b (
        .clk    (clk),
        .reset  (b_reset),
        .ready  (b_ready),
        .ra     (b_ra),
        .rd     (b_rd),
        .busy   (b_busy),
        .we3    (b_we3),
        .a3     (b_a3),
        .wd3    (b_wd3),
        .iss_en (b_iss_en),
        .iss_a  (b_iss_a)
    );

    // Reference model of the default instance
    logic [XLEN-1:0] m_rf [NREG];
    bit              m_sb [NREG];
    bit              m_ready;
    int              m_left;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    logic [B_XLEN-1:0] b_val [B_NREG];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_left  = NREG - 1;
        for (int i = 0; i < NREG; i++) m_sb[i] = 1'b0;
    endtask

    task automatic set_ra(input int r0, input int r1);
        ra = {AW'(r1), AW'(r0)};
    endtask

    // One clock of the default instance: check outputs before the edge,
    // advance the model across the edge, return at the next falling edge.
    task automatic cycle();
        logic [AW-1:0]   rai;
        logic [XLEN-1:0] erd;
        logic            eb;
        #1;
        check_val("ready", 64'(ready), 64'(m_ready));
        for (int i = 0; i < NRD; i++) begin
            rai = ra[i*AW +: AW];
            erd = (rai == '0) ? '0 : m_rf[rai];
            eb  = m_sb[rai];
`ifdef REGFILE_BYPASS_EN
            if (m_ready && we3 && (a3 != '0) && (rai == a3)) begin
                erd = wd3;
                if (!(iss_en && (iss_a == a3))) eb = 1'b0;
            end
`endif
            if (m_ready)
                check_val($sformatf("rd%0d_x%0d", i, rai), 64'(rd[i*XLEN +: XLEN]), 64'(erd));
            check_val($sformatf("busy%0d_x%0d", i, rai), 64'(busy[i]), 64'(eb));
        end
        if (we3 || iss_en || reset)
            $display("txn rst=%0d rdy=%0d we=%0d a3=%0d wd=%h iss=%0d ia=%0d", reset, m_ready, we3, a3, wd3, iss_en, iss_a);
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                for (int i = 0; i < NREG; i++) m_rf[i] = '0;
            end
        end else begin
            if (we3 && a3 != '0) begin
                m_rf[a3] = wd3;
                m_sb[a3] = 1'b0;
            end
            if (iss_en && iss_a != '0) m_sb[iss_a] = 1'b1;
        end
        @(negedge clk);
    endtask

    // Run until ready with a bounded budget and check the clear length.
    task automatic clear_run(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check_val(tag, 64'(n), 64'(NREG - 1));
    endtask

    initial begin
        int n;
        int rg;
        reset  = 1'b1; ra = '0; we3 = 1'b0; a3 = '0; wd3 = '0; iss_en = 1'b0; iss_a = '0;
        b_reset = 1'b1; b_ra = '0; b_we3 = 1'b0; b_a3 = '0; b_wd3 = '0; b_iss_en = 1'b0; b_iss_a = '0;
        for (int i = 0; i < NREG; i++) m_rf[i] = '0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        cycle();                       // reset state: ready=0, busy=0

        // Clear sequence with writes/issues that must be ignored
        reset = 1'b0;
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'h55; iss_en = 1'b1; iss_a = 5'd5;
        set_ra(5, 0);
        clear_run("clr_len");
        we3 = 1'b0; iss_en = 1'b0;
        cycle();                       // x5 still zero, not busy

        // Reset mid-clear restarts the counter
        reset = 1'b1; cycle(); reset = 1'b0;
        repeat (10) cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        clear_run("clr_len_restart");

        // Every register reads zero after clear
        for (int i = 1; i < NREG; i++) begin
            set_ra(i, NREG - i);
            cycle();
        end

        // Write/read on both ports, write to x0 discarded
        we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; set_ra(5, 5); cycle();
        we3 = 1'b0; cycle();
        we3 = 1'b1; a3 = 5'd0; wd3 = 32'h1234; set_ra(0, 0); cycle();
        we3 = 1'b0; cycle();

        // Scoreboard set, clear, set-wins and x0
        iss_en = 1'b1; iss_a = 5'd7; set_ra(7, 0); cycle();
        iss_en = 1'b0; cycle();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h77; cycle();
        we3 = 1'b0; cycle();
        iss_en = 1'b1; iss_a = 5'd7; we3 = 1'b1; a3 = 5'd7; wd3 = 32'h78; cycle();
        iss_en = 1'b0; we3 = 1'b0; cycle();
        iss_en = 1'b1; iss_a = 5'd0; cycle();
        iss_en = 1'b0; cycle();
        we3 = 1'b1; a3 = 5'd7; wd3 = 32'h79; cycle();
        we3 = 1'b0;

        // Same-cycle read of a register being written
        we3 = 1'b1; a3 = 5'd9; wd3 = 32'h11; set_ra(9, 9); cycle();
        iss_en = 1'b1; iss_a = 5'd9; cycle();
        iss_en = 1'b0; wd3 = 32'hA5A5A5A5; cycle();
        we3 = 1'b0; cycle();

        // Random traffic, biased toward a few registers to create collisions
        for (int t = 0; t < 300; t++) begin
            we3    = 1'($urandom_range(0, 1));
            a3     = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd3    = $urandom;
            iss_en = 1'($urandom_range(0, 1));
            iss_a  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            set_ra(($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1),
                   ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, NREG - 1));
            cycle();
        end
        we3 = 1'b0; iss_en = 1'b0;

        // Wide instance: clear length, packing of four 64-bit ports
        @(negedge clk);
        b_reset = 1'b0;
        n = 0;
        while (b_ready !== 1'b1 && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_val("b_clr_len", 64'(n), 64'(B_NREG - 1));
        b_val[0] = '0;
        for (int k = 1; k < B_NREG; k++) begin
            b_val[k] = {$urandom, $urandom};
            b_we3 = 1'b1; b_a3 = B_AW'(k); b_wd3 = b_val[k];
            $display("txn b we a3=%0d wd=%h", k, b_wd3);
            @(posedge clk);
            @(negedge clk);
        end
        b_we3 = 1'b0;
        for (int r = 0; r < 8; r++) begin
            for (int p = 0; p < B_NRD; p++) begin
                rg = (r == 0 && p == 0) ? 0 : 1 + ((r * B_NRD + p) % (B_NREG - 1));
                b_ra[p*B_AW +: B_AW] = B_AW'(rg);
            end
            #1;
            for (int p = 0; p < B_NRD; p++) begin
                rg = int'(b_ra[p*B_AW +: B_AW]);
                check_val($sformatf("b_rd%0d_x%0d", p, rg), b_rd[p*B_XLEN +: B_XLEN], b_val[rg]);
                check_val($sformatf("b_busy%0d", p), 64'(b_busy[p]), 64'(0));
            end
            $display("txn b read ra=%h", b_ra);
            @(posedge clk);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
